// File: rtl/led_seg_out_if.sv
// CPU store-side bus into the LED / seven-segment output port.
// The CPU (or bench) drives the master side; the peripheral listens on the slave side.
interface led_seg_out_if;
  logic        LEDCtrl;
  logic        SegCtrl;
  logic [31:0] address;
  logic [31:0] write_data;

  modport master (
    output LEDCtrl,
    output SegCtrl,
    output address,
    output write_data
  );

  modport slave (
    input LEDCtrl,
    input SegCtrl,
    input address,
    input write_data
  );
endinterface

// File: rtl/led_seg_out.sv
// Memory-mapped LED register and 8-digit multiplexed seven-segment display with
// hex, unsigned and signed decimal modes (sequential shift-add-3 conversion).
module led_seg_out #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst,
  led_seg_out_if.slave  bus,
  output logic [15:0]   led_out,
  output logic [7:0]    seg_en,
  output logic [7:0]    seg_out,
  output logic          busy
);
  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  // Digit codes: 0..15 hex nibble, plus dash and blank.
  localparam logic [4:0] CodeE     = 5'd14;
  localparam logic [4:0] CodeDash  = 5'd16;
  localparam logic [4:0] CodeBlank = 5'd31;

  logic [15:0]     led_q;
  logic [4:0]      digit_q [8];
  logic [31:0]     bin_q, bcd_q;
  logic [5:0]      cnt_q;
  logic            neg_q, busy_q;
  logic [CntW-1:0] scan_q;
  logic [2:0]      idx_q;

  logic        led_we, hex_we, udec_we, sdec_we, dec_we, ovf;
  logic [31:0] mag;
  logic [31:0] bcd_adj, bcd_nxt, bin_nxt;
  logic [4:0]  fmt [8];
  logic        lead;

  assign led_we  = bus.LEDCtrl && (bus.address == 32'hFFFF_FFF0);
  assign hex_we  = bus.SegCtrl && (bus.address == 32'hFFFF_FFF2);
  assign udec_we = bus.SegCtrl && (bus.address == 32'hFFFF_FFF4);
  assign sdec_we = bus.SegCtrl && (bus.address == 32'hFFFF_FFF6);
  assign dec_we  = udec_we || sdec_we;

  assign mag = (sdec_we && bus.write_data[31]) ? (~bus.write_data + 32'd1) : bus.write_data;
  assign ovf = udec_we ? (mag > 32'd99_999_999) : (mag > 32'd9_999_999);

  // One double-dabble step: adjust each BCD nibble, then shift the next binary bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[30:0], bin_q[31]};
    bin_nxt = {bin_q[30:0], 1'b0};
  end

  // Leading-zero blanking of the committed result; digit 0 always shows.
  always_comb begin
    lead = 1'b1;
    for (int i = 0; i < 8; i++) fmt[i] = {1'b0, bcd_nxt[4*i +: 4]};
    for (int i = 7; i >= 1; i--) begin
      if (lead && (bcd_nxt[4*i +: 4] == 4'd0)) fmt[i] = CodeBlank;
      else                                      lead = 1'b0;
    end
    if (neg_q) fmt[7] = CodeDash;
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      led_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      scan_q <= '0;
      idx_q  <= '0;
      for (int i = 0; i < 8; i++) digit_q[i] <= CodeBlank;
    end else begin
      if (led_we) led_q <= bus.write_data[15:0];

      if (hex_we) begin
        busy_q <= 1'b0;
        for (int i = 0; i < 8; i++) digit_q[i] <= {1'b0, bus.write_data[4*i +: 4]};
      end else if (dec_we) begin
        if (ovf) begin
          busy_q <= 1'b0;
          for (int i = 0; i < 8; i++) digit_q[i] <= CodeE;
        end else begin
          bin_q  <= mag;
          bcd_q  <= '0;
          cnt_q  <= 6'd32;
          neg_q  <= sdec_we && bus.write_data[31];
          busy_q <= 1'b1;
        end
      end else if (busy_q) begin
        bin_q <= bin_nxt;
        bcd_q <= bcd_nxt;
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          busy_q <= 1'b0;
          for (int i = 0; i < 8; i++) digit_q[i] <= fmt[i];
        end
      end

      if (scan_q == CntW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= idx_q + 3'd1;
      end else begin
        scan_q <= scan_q + CntW'(1);
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    glyph = 8'hC0;
      5'd1:    glyph = 8'hF9;
      5'd2:    glyph = 8'hA4;
      5'd3:    glyph = 8'hB0;
      5'd4:    glyph = 8'h99;
      5'd5:    glyph = 8'h92;
      5'd6:    glyph = 8'h82;
      5'd7:    glyph = 8'hF8;
      5'd8:    glyph = 8'h80;
      5'd9:    glyph = 8'h90;
      5'd10:   glyph = 8'h88;
      5'd11:   glyph = 8'h83;
      5'd12:   glyph = 8'hC6;
      5'd13:   glyph = 8'hA1;
      5'd14:   glyph = 8'h86;
      5'd15:   glyph = 8'h8E;
      5'd16:   glyph = 8'hBF;
      default: glyph = 8'hFF;
    endcase
  endfunction

  assign led_out = led_q;
  assign busy    = busy_q;
  assign seg_en  = ~(8'd1 << idx_q);
  assign seg_out = glyph(digit_q[idx_q]);
endmodule

// File: tb/tb_led_seg_out.sv
// Scoreboard bench for led_seg_out: expected scan words are queued at each write and
// popped against the observed digit scan; busy length and display hold are checked inline.
module tb_led_seg_out;
  localparam int unsigned ScanDiv = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] led_out;
  logic [7:0]  seg_en, seg_out;
  logic        busy;

  led_seg_out_if bus ();

  led_seg_out #(.SCAN_DIV(ScanDiv)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .led_out (led_out),
    .seg_en  (seg_en),
    .seg_out (seg_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb [$];
  logic [7:0]  cur_g [8];
  logic [7:0]  nxt_g [8];
  logic [7:0]  obs_en [8];
  logic [7:0]  obs_seg [8];
  bit          cap_ok;
  int          exp_busy;
  int          busy_cnt;

  function automatic logic [7:0] glyph_of(input int c);
    logic [7:0] tbl [18];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
            8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hBF, 8'hFF};
    return tbl[c];
  endfunction

  task automatic bus_write(input bit led, input bit seg, input logic [31:0] a,
                           input logic [31:0] d);
    @(posedge clk);
    bus.LEDCtrl = led; bus.SegCtrl = seg; bus.address = a; bus.write_data = d;
    @(posedge clk);
    bus.LEDCtrl = 1'b0; bus.SegCtrl = 1'b0; bus.address = '0; bus.write_data = '0;
  endtask

  // Queue the expected scan words for the display in nxt_g.
  task automatic push_expected();
    for (int i = 0; i < 8; i++) sb.push_back({~(8'd1 << i), nxt_g[i]});
  endtask

  task automatic model_hex(input logic [31:0] d);
    logic [31:0] v;
    v = d;
    for (int i = 0; i < 8; i++) nxt_g[i] = glyph_of(int'(v[4*i +: 4]));
    exp_busy = 0;
  endtask

  task automatic model_dec(input logic [31:0] v, input bit sgn);
    bit          neg, ovf;
    logic [31:0] m;
    longint      p;
    neg = sgn && v[31];
    m   = neg ? (32'd0 - v) : v;
    ovf = sgn ? (m > 32'd9_999_999) : (m > 32'd99_999_999);
    p   = 1;
    for (int i = 0; i < 8; i++) begin
      if (ovf)                      nxt_g[i] = 8'h86;
      else if (i > 0 && m < p)      nxt_g[i] = 8'hFF;
      else                          nxt_g[i] = glyph_of(int'((m / p) % 10));
      p = p * 10;
    end
    if (neg && !ovf) nxt_g[7] = 8'hBF;
    exp_busy = ovf ? 0 : 32;
  endtask

  // Waits for the scan to restart at digit 0, then samples each digit once.
  task automatic scan_capture();
    logic [7:0] prev;
    cap_ok = 1'b0;
    prev   = seg_en;
    for (int n = 0; n < 64 && !cap_ok; n++) begin
      @(posedge clk);
      if (seg_en == 8'hFE && prev != 8'hFE) cap_ok = 1'b1;
      else                                  prev   = seg_en;
    end
    if (cap_ok) begin
      for (int i = 0; i < 8; i++) begin
        obs_en[i]  = seg_en;
        obs_seg[i] = seg_out;
        repeat (ScanDiv) @(posedge clk);
      end
    end
  endtask

  // Counts busy cycles, checking that the old display holds while converting.
  task automatic count_busy();
    int idx;
    busy_cnt = 0;
    for (int n = 0; n < 80 && busy === 1'b1; n++) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (seg_en == ~(8'd1 << i)) idx = i;
      total++;
      if (seg_out !== cur_g[idx]) begin
        bad++;
        $display("FAIL hold digit%0d got seg=%h want seg=%h", idx, seg_out, cur_g[idx]);
      end
      busy_cnt++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.LEDCtrl = 1'b0; bus.SegCtrl = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (3) @(posedge clk);
    total++;
    if ({led_out, busy, seg_en, seg_out} !== {16'h0, 1'b0, 8'hFE, 8'hFF}) begin
      bad++;
      $display("FAIL reset got led=%h busy=%b en=%h seg=%h want 0000 0 fe ff",
               led_out, busy, seg_en, seg_out);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin nxt_g[i] = 8'hFF; cur_g[i] = 8'hFF; end
    push_expected();
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL reset_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i]} !== e) begin
        bad++;
        $display("FAIL reset_scan%0d got %h want %h", i, {obs_en[i], obs_seg[i]}, e);
      end
    end
  endtask

  task automatic test_led();
    bus_write(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0001_A5C3);
    total++;
    if ({led_out, seg_out, busy} !== {16'hA5C3, 8'hFF, 1'b0}) begin
      bad++;
      $display("FAIL led got led=%h seg=%h busy=%b want a5c3 ff 0", led_out, seg_out, busy);
    end
    bus_write(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0000_FFFF);
    total++;
    if (led_out !== 16'hA5C3) begin
      bad++;
      $display("FAIL led_bad_addr got %h want a5c3", led_out);
    end
  endtask

  task automatic test_hex(input logic [31:0] d);
    model_hex(d);
    push_expected();
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF2, d);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hex_busy got %b want 0", busy); end
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL hex_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i]} !== e) begin
        bad++;
        $display("FAIL hex_scan%0d got %h want %h", i, {obs_en[i], obs_seg[i]}, e);
      end
    end
    cur_g = nxt_g;
  endtask

  task automatic test_decimal(input logic [31:0] v, input bit sgn);
    model_dec(v, sgn);
    push_expected();
    bus_write(1'b0, 1'b1, sgn ? 32'hFFFF_FFF6 : 32'hFFFF_FFF4, v);
    count_busy();
    total++;
    if (busy_cnt !== exp_busy) begin
      bad++;
      $display("FAIL dec_busy %h got %0d cycles want %0d", v, busy_cnt, exp_busy);
    end
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL dec_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i]} !== e) begin
        bad++;
        $display("FAIL dec_scan %h digit%0d got %h want %h", v, i, {obs_en[i], obs_seg[i]}, e);
      end
    end
    cur_g = nxt_g;
  endtask

  task automatic test_back_to_back();
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF4, 32'd99);
    repeat (9) @(posedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got %b want 1", busy); end
    model_dec(32'd7, 1'b0);
    push_expected();
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF4, 32'd7);
    count_busy();
    total++;
    if (busy_cnt !== 32) begin
      bad++;
      $display("FAIL b2b_busy got %0d cycles want 32", busy_cnt);
    end
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL b2b_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i]} !== e) begin
        bad++;
        $display("FAIL b2b_scan%0d got %h want %h", i, {obs_en[i], obs_seg[i]}, e);
      end
    end
    cur_g = nxt_g;
  endtask

  task automatic test_hex_abort();
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF4, 32'd55555);
    repeat (5) @(posedge clk);
    model_hex(32'hFEDC_BA98);
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF2, 32'hFEDC_BA98);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (40) @(posedge clk);
    push_expected();
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL abort_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i], busy} !== {e, 1'b0}) begin
        bad++;
        $display("FAIL abort_scan%0d got %h busy=%b want %h busy=0",
                 i, {obs_en[i], obs_seg[i]}, busy, e);
      end
    end
    cur_g = nxt_g;
  endtask

  task automatic test_ignored();
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000);
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h1111_1111);
    nxt_g = cur_g;
    push_expected();
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL ignore_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i], busy} !== {e, 1'b0}) begin
        bad++;
        $display("FAIL ignore_scan%0d got %h busy=%b want %h busy=0",
                 i, {obs_en[i], obs_seg[i]}, busy, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus_write(1'b0, 1'b1, 32'hFFFF_FFF4, 32'd1234);
    repeat (5) @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    total++;
    if ({busy, seg_en, seg_out, led_out} !== {1'b0, 8'hFE, 8'hFF, 16'h0}) begin
      bad++;
      $display("FAIL rst_mid got busy=%b en=%h seg=%h led=%h want 0 fe ff 0000",
               busy, seg_en, seg_out, led_out);
    end
    repeat (40) @(posedge clk);
    for (int i = 0; i < 8; i++) nxt_g[i] = 8'hFF;
    push_expected();
    scan_capture();
    total++;
    if (!cap_ok) begin bad++; sb.delete(); $display("FAIL rst_mid_scan got timeout want scan"); end
    else for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = sb.pop_front();
      total++;
      if ({obs_en[i], obs_seg[i]} !== e) begin
        bad++;
        $display("FAIL rst_mid_scan%0d got %h want %h", i, {obs_en[i], obs_seg[i]}, e);
      end
    end
    cur_g = nxt_g;
  endtask

  initial begin
    test_reset();
    test_led();
    test_hex(32'h1234_ABCD);
    test_decimal(32'd12345678, 1'b0);
    test_decimal(32'hFFFF_FECF, 1'b1);
    test_decimal(32'd100_000_000, 1'b0);
    test_decimal(32'h8000_0000, 1'b1);
    test_decimal(32'd0, 1'b0);
    test_decimal(32'd99_999_999, 1'b0);
    test_decimal(32'd9_999_999, 1'b1);
    test_decimal(32'd10_000_000, 1'b1);
    test_decimal(32'hFF67_6981, 1'b1);
    test_back_to_back();
    test_hex_abort();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
